hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_md_timer.sv | 27 ++
 rtl/hazard_ctrl.sv | 93 +++++++++
 tb/tb_hazard_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared state encoding and timing constants for hazard_ctrl
package hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        HZ_RUN     = 1'b0,
        HZ_MEMWAIT = 1'b1
    } hz_state_e;

    localparam int         MD_W     = 6;
    localparam logic [5:0] MULT_CYC = 6'd4;
    localparam logic [5:0] DIV_CYC  = 6'd32;
    localparam logic [7:0] MEM_TMO  = 8'd255;

    function automatic logic [MD_W-1:0] md_length(input logic is_div);
        return is_div ? DIV_CYC : MULT_CYC;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_timer.sv
// rtl/hazard_ctrl_md_timer.sv - HI/LO occupancy counter for multiply/divide
module hazard_ctrl_md_timer
    import hazard_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [MD_W-1:0] length,
    output logic            busy
);

    logic [MD_W-1:0] md_cnt;

    // The issue cycle is the first occupied cycle, so length-1 cycles remain after it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (load) begin
            md_cnt <= length - 6'd1;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 6'd1;
        end
    end

    assign busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: freeze, flush, load-use and HI/LO interlocks
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs_addr,
    input  logic [4:0]  ID_rt_addr,
    input  logic        ID_uses_rt,
    input  logic        ID_md_start,
    input  logic        ID_md_is_div,
    input  logic        ID_reads_hilo,
    input  logic        EX_memread,
    input  logic [4:0]  EX_rd_addr,
    input  logic        EX_branch_taken,
    input  logic        MEM_req,
    input  logic        MEM_ack,
    output logic        PC_write,
    output logic        IFID_write,
    output logic        IDEX_bubble,
    output logic        IFID_flush,
    output logic        pipe_freeze,
    output logic        md_busy,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt
);

    hz_state_e       state, state_next;
    logic [7:0]      wait_cnt;
    logic            freeze, flush, load_use, hilo_stall, md_accept;
    logic [MD_W-1:0] md_len;

    assign freeze     = MEM_req & ~MEM_ack;
    assign flush      = ~freeze & EX_branch_taken;
    assign load_use   = EX_memread & (EX_rd_addr != 5'd0) &
                        ((EX_rd_addr == ID_rs_addr) | (ID_uses_rt & (EX_rd_addr == ID_rt_addr)));
    assign hilo_stall = md_busy & (ID_md_start | ID_reads_hilo);
    assign md_accept  = ID_md_start & ~freeze & ~flush & ~load_use & ~hilo_stall;
    assign md_len     = md_length(ID_md_is_div);

    hazard_ctrl_md_timer md_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (md_accept),
        .length (md_len),
        .busy   (md_busy)
    );

    always_comb begin
        state_next  = state;
        PC_write    = 1'b1;
        IFID_write  = 1'b1;
        IDEX_bubble = 1'b0;
        IFID_flush  = 1'b0;
        pipe_freeze = 1'b0;
        case (state)
            HZ_RUN:     if (freeze)  state_next = HZ_MEMWAIT;
            HZ_MEMWAIT: if (MEM_ack) state_next = HZ_RUN;
        endcase
        if (freeze) begin
            pipe_freeze = 1'b1;
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
        end else if (EX_branch_taken) begin
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
        end else if (load_use || hilo_stall) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
        end
    end

    // mem_timeout is set on the same edge that wait_cnt reaches MEM_TMO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HZ_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == HZ_RUN) begin
                if (freeze) wait_cnt <= '0;
            end else if (wait_cnt != MEM_TMO) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if ((state == HZ_MEMWAIT) && (wait_cnt == MEM_TMO - 8'd1)) mem_timeout <= 1'b1;
            if (!PC_write && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl with behavioural model
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_rs_addr, ID_rt_addr, EX_rd_addr;
    logic        ID_uses_rt, ID_md_start, ID_md_is_div, ID_reads_hilo;
    logic        EX_memread, EX_branch_taken, MEM_req, MEM_ack;
    logic        PC_write, IFID_write, IDEX_bubble, IFID_flush, pipe_freeze;
    logic        md_busy, mem_timeout;
    logic [15:0] stall_cnt;

    int tests_run = 0;
    int fails = 0;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .ID_rs_addr(ID_rs_addr), .ID_rt_addr(ID_rt_addr), .ID_uses_rt(ID_uses_rt),
        .ID_md_start(ID_md_start), .ID_md_is_div(ID_md_is_div), .ID_reads_hilo(ID_reads_hilo),
        .EX_memread(EX_memread), .EX_rd_addr(EX_rd_addr), .EX_branch_taken(EX_branch_taken),
        .MEM_req(MEM_req), .MEM_ack(MEM_ack),
        .PC_write(PC_write), .IFID_write(IFID_write), .IDEX_bubble(IDEX_bubble),
        .IFID_flush(IFID_flush), .pipe_freeze(pipe_freeze),
        .md_busy(md_busy), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model state: occupancy as an absolute release cycle, memory wait as a plain counter.
    int cyc = 0;
    int busy_until = 0;
    bit m_wait = 0;
    int m_wait_n = 0;
    bit m_timeout = 0;
    int m_stall = 0;

    always @(negedge clk) begin
        bit frz, mb, lu, hl, e_pc, e_ifid, e_bub, e_fl, e_frz;
        if (reset) begin
            m_wait = 0; m_wait_n = 0; m_timeout = 0; m_stall = 0; busy_until = 0;
            chk("reset_md_busy", int'(md_busy), 0);
            chk("reset_mem_timeout", int'(mem_timeout), 0);
            chk("reset_stall_cnt", int'(stall_cnt), 0);
        end else begin
            frz = MEM_req && !MEM_ack;
            mb  = cyc < busy_until;
            lu  = EX_memread && EX_rd_addr != 0 &&
                  (EX_rd_addr == ID_rs_addr || (ID_uses_rt && EX_rd_addr == ID_rt_addr));
            hl  = mb && (ID_md_start || ID_reads_hilo);
            e_pc = 1; e_ifid = 1; e_bub = 0; e_fl = 0; e_frz = 0;
            if (frz) begin
                e_frz = 1; e_pc = 0; e_ifid = 0;
            end else if (EX_branch_taken) begin
                e_fl = 1; e_bub = 1;
            end else if (lu || hl) begin
                e_pc = 0; e_ifid = 0; e_bub = 1;
            end
            chk("ctrl{pc,ifid,bub,flush,freeze}",
                int'({PC_write, IFID_write, IDEX_bubble, IFID_flush, pipe_freeze}),
                int'({e_pc, e_ifid, e_bub, e_fl, e_frz}));
            chk("md_busy", int'(md_busy), int'(mb));
            chk("mem_timeout", int'(mem_timeout), int'(m_timeout));
            chk("stall_cnt", int'(stall_cnt), m_stall);

            if (!m_wait) begin
                if (frz) begin m_wait = 1; m_wait_n = 0; end
            end else begin
                if (m_wait_n < 255) m_wait_n++;
                if (m_wait_n == 255) m_timeout = 1;
                if (MEM_ack) m_wait = 0;
            end
            if (ID_md_start && !frz && !EX_branch_taken && !lu && !hl)
                busy_until = cyc + (ID_md_is_div ? 32 : 4);
            if (!e_pc && m_stall < 65535) m_stall++;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        ID_rs_addr = 0; ID_rt_addr = 0; ID_uses_rt = 0; ID_md_start = 0; ID_md_is_div = 0;
        ID_reads_hilo = 0; EX_memread = 0; EX_rd_addr = 0; EX_branch_taken = 0;
        MEM_req = 0; MEM_ack = 0;
    endtask

    task automatic do_reset();
        idle(); reset = 1; tick(); reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        chk("post_reset_pc", int'(PC_write), 1);
        chk("post_reset_bubble", int'(IDEX_bubble), 0);
        tick();

        // load-use on rs, then the same with $zero as destination
        EX_memread = 1; EX_rd_addr = 5; ID_rs_addr = 5; #1;
        chk("lu_pc", int'(PC_write), 0);
        chk("lu_bubble", int'(IDEX_bubble), 1);
        tick();
        EX_rd_addr = 0; ID_rs_addr = 0; #1;
        chk("lu_r0_pc", int'(PC_write), 1);
        chk("lu_r0_bubble", int'(IDEX_bubble), 0);
        tick();

        // load-use coincident with a taken branch
        EX_rd_addr = 5; ID_rs_addr = 5; EX_branch_taken = 1; #1;
        chk("br_flush", int'(IFID_flush), 1);
        chk("br_bubble", int'(IDEX_bubble), 1);
        chk("br_pc", int'(PC_write), 1);
        tick();

        // DIV then MFLO
        do_reset();
        ID_md_start = 1; ID_md_is_div = 1; tick();
        idle(); ID_reads_hilo = 1; #1;
        n = 0;
        while (PC_write == 0 && n < 100) begin
            n++; tick();
        end
        chk("div_stall_cycles", n, 31);
        chk("div_stall_cnt", int'(stall_cnt), 31);
        chk("div_done_busy", int'(md_busy), 0);
        tick(); idle();

        // memory freeze for three cycles then ack
        do_reset();
        MEM_req = 1; n = 0;
        for (int i = 0; i < 3; i++) begin
            #1; n += int'(pipe_freeze); tick();
        end
        chk("mem_freeze_cycles", n, 3);
        MEM_ack = 1; #1;
        chk("mem_ack_freeze", int'(pipe_freeze), 0);
        chk("mem_ack_stall_cnt", int'(stall_cnt), 3);
        tick(); idle(); #1;
        chk("mem_after_pc", int'(PC_write), 1);
        tick();

        // long wait: timeout after 255 MEMWAIT cycles, sticky past ack
        do_reset();
        MEM_req = 1;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (i == 255) chk("tmo_before", int'(mem_timeout), 0);
            if (i == 256) chk("tmo_after", int'(mem_timeout), 1);
            tick();
        end
        MEM_ack = 1; tick(); idle(); tick(); #1;
        chk("tmo_sticky", int'(mem_timeout), 1);
        reset = 1; #1;
        chk("tmo_reset", int'(mem_timeout), 0);
        tick(); reset = 0;

        // reset in the middle of a divide
        tick();
        ID_md_start = 1; ID_md_is_div = 1; tick();
        idle();
        for (int i = 0; i < 10; i++) tick();
        #1;
        chk("div_mid_busy", int'(md_busy), 1);
        reset = 1; #1;
        chk("div_reset_busy", int'(md_busy), 0);
        tick(); reset = 0;
        ID_reads_hilo = 1; #1;
        chk("mfhi_after_reset_pc", int'(PC_write), 1);
        chk("mfhi_after_reset_bubble", int'(IDEX_bubble), 0);
        tick();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ID_rs_addr      = 5'($urandom_range(0, 3));
            ID_rt_addr      = 5'($urandom_range(0, 3));
            EX_rd_addr      = 5'($urandom_range(0, 3));
            ID_uses_rt      = 1'($urandom_range(0, 1));
            EX_memread      = ($urandom_range(0, 99) < 30);
            EX_branch_taken = ($urandom_range(0, 99) < 10);
            ID_md_start     = ($urandom_range(0, 99) < 10);
            ID_md_is_div    = 1'($urandom_range(0, 1));
            ID_reads_hilo   = ($urandom_range(0, 99) < 20);
            MEM_req         = ($urandom_range(0, 99) < 20);
            MEM_ack         = 1'($urandom_range(0, 1));
            reset           = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 0; idle();
        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
